// File: rtl/buffer_pointer_ctrl.sv
// buffer_pointer_ctrl: address and occupancy controller for a 1W/1R buffer RAM.
// The block holds no data. It qualifies push/pop requests, drives the RAM strobes
// and addresses, tracks occupancy, and reports rejected requests as error pulses.
//
// Request semantics: push and pop are requests with no ready signal returned.
// A request is taken in the cycle it is presented only if its strobe (wr_en / rd_en)
// is high in that same cycle. Otherwise it is dropped, and the next cycle carries a
// one-cycle overflow / underflow pulse. flush drops both requests silently.
module buffer_pointer_ctrl #(
  parameter int    DEPTH        = 8,
  parameter string POP_ORDER    = "FIFO",
  parameter int    ALMOST_FULL  = DEPTH - 1,
  parameter int    ALMOST_EMPTY = 1,
  localparam int   AW           = $clog2(DEPTH),
  localparam int   CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          overflow,
  output logic          underflow
);

  if ((POP_ORDER != "FIFO") && (POP_ORDER != "LIFO")) begin : g_bad_order
    $fatal(1, "buffer_pointer_ctrl: POP_ORDER must be \"FIFO\" or \"LIFO\"");
  end

  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  // Flags are decoded from the registered count only.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CW'(DEPTH));
  assign almost_full  = (count_q >= CW'(ALMOST_FULL));
  assign almost_empty = (count_q <= CW'(ALMOST_EMPTY));
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Request qualification. A full buffer still takes a push when a pop is taken in
  // the same cycle. Reset forces the strobes low combinationally.
  always_comb begin
    pop_ok      = pop & ~empty & ~flush & ~rst;
    push_ok     = push & ~flush & ~rst & (~full | pop_ok);
    wr_en       = push_ok;
    rd_en       = pop_ok;
    overflow_d  = push & ~push_ok & ~flush;
    underflow_d = pop & ~pop_ok & ~flush;
    count_d     = count_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) begin
      count_d = '0;
    end
  end

  // Occupancy and error-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (POP_ORDER == "FIFO") begin : g_fifo
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;

    assign wr_addr = wr_ptr_q;
    assign rd_addr = rd_ptr_q;

    // Pointer advance. The wrap compares against DEPTH-1 so DEPTH need not be a power of two.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (flush) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end else begin
        if (push_ok) begin
          wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
          rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
        end
      end
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
      end
    end
  end else begin : g_lifo
    // The stack pointer is the count itself. top is the newest entry; slot is the
    // first free entry, clamped to DEPTH-1 when the stack is full.
    logic [AW-1:0] top_addr;
    logic [AW-1:0] slot_addr;

    // Stack addressing. A push with a pop replaces the top entry in place, which
    // relies on the RAM returning the old contents on a same-address read/write.
    always_comb begin
      top_addr  = empty ? '0 : AW'(count_q - CW'(1));
      slot_addr = full ? AW'(DEPTH - 1) : AW'(count_q);
      rd_addr   = top_addr;
      wr_addr   = slot_addr;
      if (push_ok && pop_ok) begin
        wr_addr = top_addr;
      end
    end
  end

endmodule

// File: tb/tb_buffer_pointer_ctrl.sv
// tb_buffer_pointer_ctrl: drives a FIFO instance (DEPTH=5) and a LIFO instance
// (DEPTH=4) with the same request stream. Each instance is checked against a
// queue-based reference model and a bench-side read-first RAM.
module tb_buffer_pointer_ctrl;

  localparam int FD = 5;
  localparam int LD = 4;
  localparam int AF = 3;
  localparam int AE = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic push, pop, flush;
  always #5 clk = ~clk;

  logic       f_wr_en, f_rd_en, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_wr_addr, f_rd_addr, f_count;
  logic       l_wr_en, l_rd_en, l_full, l_empty, l_af, l_ae, l_ovf, l_unf;
  logic [1:0] l_wr_addr, l_rd_addr;
  logic [2:0] l_count;

  buffer_pointer_ctrl #(.DEPTH(FD), .POP_ORDER("FIFO"), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wr_en(f_wr_en), .rd_en(f_rd_en), .wr_addr(f_wr_addr), .rd_addr(f_rd_addr),
    .count(f_count), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf), .underflow(f_unf)
  );

  buffer_pointer_ctrl #(.DEPTH(LD), .POP_ORDER("LIFO")) u_lifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush),
    .wr_en(l_wr_en), .rd_en(l_rd_en), .wr_addr(l_wr_addr), .rd_addr(l_rd_addr),
    .count(l_count), .full(l_full), .empty(l_empty),
    .almost_full(l_af), .almost_empty(l_ae), .overflow(l_ovf), .underflow(l_unf)
  );

  // ---------------- reference model ----------------
  // Index 0 = FIFO instance, 1 = LIFO instance.
  int          m_cnt[2];
  int          m_wi[2];    // FIFO: accepted pushes modulo DEPTH since clear
  int          m_ri[2];    // FIFO: accepted pops modulo DEPTH since clear
  bit          m_ovf[2];
  bit          m_unf[2];
  logic [7:0]  exp_q_f[$];
  logic [7:0]  exp_q_l[$];
  logic [7:0]  mem_f[FD];
  logic [7:0]  mem_l[LD];
  logic [7:0]  wdata;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_cnt[m] = 0; m_wi[m] = 0; m_ri[m] = 0; m_ovf[m] = 0; m_unf[m] = 0;
    end
    exp_q_f.delete();
    exp_q_l.delete();
  endtask

  // Compare one instance against the model for the inputs now applied, then
  // advance the model to the state expected after the coming rising edge.
  task automatic check_dut(input int m);
    logic       we, re, fl, em, af, ae, ov, un;
    int         wa, ra, cnt, d, ewa, era;
    bit         pok, wok;
    logic [7:0] rd, expv;
    string      nm;
    if (m == 0) begin
      nm = "fifo"; d = FD;
      we = f_wr_en; re = f_rd_en; wa = int'(f_wr_addr); ra = int'(f_rd_addr); cnt = int'(f_count);
      fl = f_full; em = f_empty; af = f_af; ae = f_ae; ov = f_ovf; un = f_unf;
    end else begin
      nm = "lifo"; d = LD;
      we = l_wr_en; re = l_rd_en; wa = int'(l_wr_addr); ra = int'(l_rd_addr); cnt = int'(l_count);
      fl = l_full; em = l_empty; af = l_af; ae = l_ae; ov = l_ovf; un = l_unf;
    end

    pok = !rst && pop && (m_cnt[m] != 0) && !flush;
    wok = !rst && push && !flush && ((m_cnt[m] != d) || pok);

    if (m == 0) begin
      ewa = m_wi[m];
      era = m_ri[m];
    end else begin
      era = (m_cnt[m] == 0) ? 0 : m_cnt[m] - 1;
      ewa = (pok && wok) ? era : ((m_cnt[m] == d) ? d - 1 : m_cnt[m]);
    end

    check({nm, ".wr_en"}, we, wok);
    check({nm, ".rd_en"}, re, pok);
    check({nm, ".count"}, cnt, m_cnt[m]);
    check({nm, ".full"}, fl, m_cnt[m] == d);
    check({nm, ".empty"}, em, m_cnt[m] == 0);
    check({nm, ".almost_full"}, af, m_cnt[m] >= AF);
    check({nm, ".almost_empty"}, ae, m_cnt[m] <= AE);
    check({nm, ".overflow"}, ov, m_ovf[m]);
    check({nm, ".underflow"}, un, m_unf[m]);
    if (!rst) begin
      check({nm, ".wr_addr"}, wa, ewa);
      check({nm, ".rd_addr"}, ra, era);
    end

    if (rst) return;

    // Read-first RAM: the read sees the old contents, then the write lands.
    if (pok) begin
      expv = (m == 0) ? exp_q_f.pop_front() : exp_q_l.pop_back();
      if (re && ra < d) begin
        rd = (m == 0) ? mem_f[ra] : mem_l[ra];
        check({nm, ".rd_data"}, rd, expv);
      end
    end
    if (wok) begin
      if (m == 0) exp_q_f.push_back(wdata);
      else        exp_q_l.push_back(wdata);
    end
    if (we && wa < d) begin
      if (m == 0) mem_f[wa] = wdata;
      else        mem_l[wa] = wdata;
    end

    m_ovf[m] = push && !wok && !flush;
    m_unf[m] = pop && !pok && !flush;
    if (flush) begin
      m_cnt[m] = 0; m_wi[m] = 0; m_ri[m] = 0;
      if (m == 0) exp_q_f.delete();
      else        exp_q_l.delete();
    end else begin
      m_cnt[m] = m_cnt[m] + int'(wok) - int'(pok);
      m_wi[m]  = (m_wi[m] + int'(wok)) % d;
      m_ri[m]  = (m_ri[m] + int'(pok)) % d;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input bit p, input bit q, input bit f);
    @(negedge clk);
    push  = p;
    pop   = q;
    flush = f;
    wdata = 8'($urandom);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  // Asynchronous reset pulse raised between edges, with a push still requested.
  task automatic pulse_reset();
    @(negedge clk);
    rst  = 1'b1;
    push = 1'b1;
    pop  = 1'b0;
    flush = 1'b0;
    #1;
    model_reset();
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst  = 1'b0;
    push = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; wdata = '0;
    for (int i = 0; i < FD; i++) mem_f[i] = '0;
    for (int i = 0; i < LD; i++) mem_l[i] = '0;
    model_reset();
    #2;
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, pass-through on full, rejected push and its single-cycle pulse.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // Drain, push+pop on empty, then pop the single entry.
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);

    // Stack pattern: three pushes, pop, replace-top.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 0, 0);

    // Flush with a push requested, then idle.
    cyc(1, 0, 0);
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    cyc(1, 1, 1);
    cyc(0, 0, 0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    pulse_reset();
    cyc(0, 0, 0);

    // Randomized phases biased toward filling, balanced, and draining.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      pp = ((i / 120) % 3 == 0) ? 75 : (((i / 120) % 3 == 1) ? 50 : 25);
      if ($urandom_range(399) == 0) begin
        pulse_reset();
      end else begin
        cyc($urandom_range(99) < pp, $urandom_range(99) < (100 - pp),
            $urandom_range(39) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
